// File: rtl/stack_ctrl.sv
// Command sequencer for a pair of 8-bit stacks: single commands plus DUP/SWAP/MOVE micro-sequences.
// Optional SWAP support is compiled in when STACK_CTRL_SWAP_EN is defined.
module stack_ctrl #(
  parameter bit RESET_SEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       stack_select,
  output logic       push,
  output logic       pop,
  output logic [7:0] stk_wdata,
  input  logic [7:0] stk_rdata,
  input  logic [1:0] stk_empty,
  input  logic [1:0] stk_full
);

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_SEL    = 3'b000;
  localparam logic [2:0] OP_PUSH   = 3'b001;
  localparam logic [2:0] OP_POP    = 3'b010;
  localparam logic [2:0] OP_PEEK   = 3'b011;
  localparam logic [2:0] OP_DUP    = 3'b100;
  localparam logic [2:0] OP_SWAP   = 3'b101;
  localparam logic [2:0] OP_MOVE   = 3'b110;
  localparam logic [2:0] OP_STATUS = 3'b111;

  typedef enum logic [3:0] {
    IDLE,
    EXEC,
    DUP_PUSH,
`ifdef STACK_CTRL_SWAP_EN
    SWAP_POP2,
    SWAP_PUSHA,
    SWAP_PUSHB,
    SWAP_RESTORE,
`endif
    MOVE_PUSH,
    RESP
  } state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   top_a;
  logic [DATA_W-1:0]   top_b;
  logic                sel_empty;
  logic                sel_full;
  logic                other_full;

  assign sel_empty  = stk_empty[stack_select];
  assign sel_full   = stk_full[stack_select];
  assign other_full = stk_full[~stack_select];

  assign cmd_ready = rst_n & (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Strobes are masked while reset is low so an aborted sequence cannot touch a stack.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    stk_wdata = '0;
    if (rst_n) begin
      case (state)
        EXEC: begin
          case (op_q)
            OP_PUSH: begin
              push      = ~sel_full;
              stk_wdata = data_q;
            end
            OP_POP:  pop = ~sel_empty;
`ifdef STACK_CTRL_SWAP_EN
            OP_SWAP: pop = ~sel_empty;
`endif
            OP_MOVE: pop = ~sel_empty & ~other_full;
            default: ;
          endcase
        end
        DUP_PUSH, MOVE_PUSH: begin
          push      = 1'b1;
          stk_wdata = top_a;
        end
`ifdef STACK_CTRL_SWAP_EN
        SWAP_POP2: pop = ~sel_empty;
        SWAP_PUSHA, SWAP_RESTORE: begin
          push      = 1'b1;
          stk_wdata = top_a;
        end
        SWAP_PUSHB: begin
          push      = 1'b1;
          stk_wdata = top_b;
        end
`endif
        default: ;
      endcase
    end
  end

  // rsp_data/rsp_err are only written on the transition into RESP so they hold between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      stack_select <= RESET_SEL;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            if (cmd_op == OP_SEL) stack_select <= cmd_data[0];
            state  <= EXEC;
          end
        end
        EXEC: begin
          case (op_q)
            OP_SEL: begin
              rsp_data <= '0;
              rsp_err  <= 1'b0;
              state    <= RESP;
            end
            OP_PUSH: begin
              rsp_data <= data_q;
              rsp_err  <= sel_full;
              state    <= RESP;
            end
            OP_POP, OP_PEEK: begin
              rsp_data <= sel_empty ? '0 : stk_rdata;
              rsp_err  <= sel_empty;
              state    <= RESP;
            end
            OP_DUP: begin
              if (sel_empty | sel_full) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
                state    <= RESP;
              end else begin
                top_a <= stk_rdata;
                state <= DUP_PUSH;
              end
            end
            OP_SWAP: begin
`ifdef STACK_CTRL_SWAP_EN
              if (sel_empty) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
                state    <= RESP;
              end else begin
                top_a <= stk_rdata;
                state <= SWAP_POP2;
              end
`else
              rsp_data <= '0;
              rsp_err  <= 1'b1;
              state    <= RESP;
`endif
            end
            OP_MOVE: begin
              if (sel_empty | other_full) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
                state    <= RESP;
              end else begin
                top_a        <= stk_rdata;
                stack_select <= ~stack_select;
                state        <= MOVE_PUSH;
              end
            end
            default: begin
              rsp_data <= {4'b0, stk_full[1], stk_empty[1], stk_full[0], stk_empty[0]};
              rsp_err  <= 1'b0;
              state    <= RESP;
            end
          endcase
        end
        DUP_PUSH: begin
          rsp_data <= top_a;
          rsp_err  <= 1'b0;
          state    <= RESP;
        end
`ifdef STACK_CTRL_SWAP_EN
        SWAP_POP2: begin
          if (sel_empty) begin
            state <= SWAP_RESTORE;
          end else begin
            top_b <= stk_rdata;
            state <= SWAP_PUSHA;
          end
        end
        SWAP_PUSHA: state <= SWAP_PUSHB;
        SWAP_PUSHB: begin
          rsp_data <= top_b;
          rsp_err  <= 1'b0;
          state    <= RESP;
        end
        SWAP_RESTORE: begin
          rsp_data <= top_a;
          rsp_err  <= 1'b1;
          state    <= RESP;
        end
`endif
        MOVE_PUSH: begin
          // Push lands on the destination, then selection returns to the source stack.
          stack_select <= ~stack_select;
          rsp_data     <= top_a;
          rsp_err      <= 1'b0;
          state        <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl with two behavioural 16-deep stacks attached.
// Honours STACK_CTRL_SWAP_EN the same way the design does.
module tb_stack_ctrl;

  localparam logic [2:0] OP_SEL    = 3'b000;
  localparam logic [2:0] OP_PUSH   = 3'b001;
  localparam logic [2:0] OP_POP    = 3'b010;
  localparam logic [2:0] OP_PEEK   = 3'b011;
  localparam logic [2:0] OP_DUP    = 3'b100;
  localparam logic [2:0] OP_SWAP   = 3'b101;
  localparam logic [2:0] OP_MOVE   = 3'b110;
  localparam logic [2:0] OP_STATUS = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       stack_select;
  logic       push;
  logic       pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata;
  logic [1:0] stk_empty;
  logic [1:0] stk_full;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .stack_select(stack_select), .push(push), .pop(pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .stk_empty(stk_empty), .stk_full(stk_full)
  );

  // Two stack instances; read data follows the select registered one edge earlier.
  logic [7:0] mem [2][16];
  logic [4:0] cnt [2];
  logic       sel_q;
  logic       model_clr;

  always @(posedge clk) begin
    sel_q <= stack_select;
    if (model_clr) begin
      cnt[0] <= 5'd0;
      cnt[1] <= 5'd0;
    end else if (push && cnt[stack_select] < 5'd16) begin
      mem[stack_select][cnt[stack_select][3:0]] <= stk_wdata;
      cnt[stack_select] <= cnt[stack_select] + 5'd1;
    end else if (pop && cnt[stack_select] != 5'd0) begin
      cnt[stack_select] <= cnt[stack_select] - 5'd1;
    end
  end

  always_comb begin
    stk_rdata = 8'h00;
    if (cnt[sel_q] != 5'd0) stk_rdata = mem[sel_q][4'(cnt[sel_q] - 5'd1)];
    stk_empty[0] = (cnt[0] == 5'd0);
    stk_empty[1] = (cnt[1] == 5'd0);
    stk_full[0]  = (cnt[0] == 5'd16);
    stk_full[1]  = (cnt[1] == 5'd16);
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response strobe.
  always @(negedge clk) begin
    if (push || pop) begin
      checks++;
      if (push && pop) begin
        errors++;
        $display("FAIL push_pop_overlap: push=%0b pop=%0b at cycle %0d", push, pop, cyc);
      end
    end
    if (rsp_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got data %02h err %0b at cycle %0d, expected none",
                 rsp_data, rsp_err, cyc);
      end else begin
        me = q.pop_front();
        if (rsp_data !== me.data || rsp_err !== me.err || cyc != me.cyc) begin
          errors++;
          $display("FAIL rsp: got data %02h err %0b cycle %0d, expected data %02h err %0b cycle %0d",
                   rsp_data, rsp_err, cyc, me.data, me.err, me.cyc);
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] d,
                      input logic [7:0] ed, input logic ee, input int k);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", {31'b0, cmd_ready}, 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    e.data = ed;
    e.err  = ee;
    e.cyc  = cyc + 1 + k;
    q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      check("rsp_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    model_clr = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    model_clr = 1'b0;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_outputs", {16'b0, rsp_valid, rsp_err, push, pop, stack_select, 3'b0, stk_wdata},
          32'd0);
    check("rst_rsp_data", {24'b0, rsp_data}, 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'b0, cmd_ready}, 32'd1);

    send(OP_STATUS, 8'h00, 8'h05, 1'b0, 1);
    send(OP_PUSH, 8'h11, 8'h11, 1'b0, 1);
    send(OP_PUSH, 8'h22, 8'h22, 1'b0, 1);
    send(OP_POP,  8'h00, 8'h22, 1'b0, 1);
    send(OP_POP,  8'h00, 8'h11, 1'b0, 1);
    send(OP_POP,  8'h00, 8'h00, 1'b1, 1);

    send(OP_PUSH, 8'h33, 8'h33, 1'b0, 1);
    send(OP_DUP,  8'h00, 8'h33, 1'b0, 2);
    check("dup_count", {27'b0, cnt[0]}, 32'd2);
    send(OP_POP,  8'h00, 8'h33, 1'b0, 1);
    send(OP_POP,  8'h00, 8'h33, 1'b0, 1);
    send(OP_DUP,  8'h00, 8'h00, 1'b1, 1);

`ifdef STACK_CTRL_SWAP_EN
    send(OP_PUSH, 8'h01, 8'h01, 1'b0, 1);
    send(OP_PUSH, 8'h02, 8'h02, 1'b0, 1);
    send(OP_SWAP, 8'h00, 8'h01, 1'b0, 4);
    send(OP_POP,  8'h00, 8'h01, 1'b0, 1);
    send(OP_POP,  8'h00, 8'h02, 1'b0, 1);
    send(OP_PUSH, 8'h07, 8'h07, 1'b0, 1);
    send(OP_SWAP, 8'h00, 8'h07, 1'b1, 3);
    check("swap_err_count", {27'b0, cnt[0]}, 32'd1);
    send(OP_POP,  8'h00, 8'h07, 1'b0, 1);
`else
    send(OP_PUSH, 8'h01, 8'h01, 1'b0, 1);
    send(OP_SWAP, 8'h00, 8'h00, 1'b1, 1);
    check("swap_off_count", {27'b0, cnt[0]}, 32'd1);
    send(OP_POP,  8'h00, 8'h01, 1'b0, 1);
`endif

    send(OP_PUSH, 8'h5A, 8'h5A, 1'b0, 1);
    send(OP_MOVE, 8'h00, 8'h5A, 1'b0, 2);
    check("move_select", {31'b0, stack_select}, 32'd0);
    check("move_counts", {11'b0, cnt[1], 11'b0, cnt[0]}, {11'b0, 5'd1, 11'b0, 5'd0});
    send(OP_SEL,  8'h01, 8'h00, 1'b0, 1);
    check("sel_select", {31'b0, stack_select}, 32'd1);
    send(OP_PEEK, 8'h00, 8'h5A, 1'b0, 1);
    for (int i = 1; i <= 15; i++) send(OP_PUSH, 8'(8'h80 + i), 8'(8'h80 + i), 1'b0, 1);
    send(OP_SEL,  8'h00, 8'h00, 1'b0, 1);
    send(OP_PUSH, 8'h44, 8'h44, 1'b0, 1);
    send(OP_MOVE, 8'h00, 8'h00, 1'b1, 1);
    check("move_full_counts", {11'b0, cnt[1], 11'b0, cnt[0]}, {11'b0, 5'd16, 11'b0, 5'd1});
    send(OP_PEEK, 8'h00, 8'h44, 1'b0, 1);

    for (int i = 1; i <= 15; i++) send(OP_PUSH, 8'(8'h60 + i), 8'(8'h60 + i), 1'b0, 1);
    send(OP_PUSH, 8'hAA, 8'hAA, 1'b1, 1);
    check("full_count", {27'b0, cnt[0]}, 32'd16);
    send(OP_PEEK, 8'h00, 8'h6F, 1'b0, 1);
    send(OP_SEL,  8'h01, 8'h00, 1'b0, 1);
    send(OP_POP,  8'h00, 8'h8F, 1'b0, 1);
    send(OP_SEL,  8'h00, 8'h00, 1'b0, 1);
    send(OP_STATUS, 8'h00, 8'h02, 1'b0, 1);

    // Abort a compound command with reset while its push strobe is active.
    @(negedge clk);
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1;
`ifdef STACK_CTRL_SWAP_EN
    cmd_op = OP_SWAP;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
`else
    cmd_op = OP_MOVE;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
`endif
    check("push_before_abort", {31'b0, push}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("abort_outputs", {16'b0, rsp_valid, rsp_err, push, pop, stack_select, 3'b0, stk_wdata},
          32'd0);
    check("abort_rsp_data", {24'b0, rsp_data}, 32'h00);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_ready", {31'b0, cmd_ready}, 32'd1);
`ifdef STACK_CTRL_SWAP_EN
    check("abort_counts", {11'b0, cnt[1], 11'b0, cnt[0]}, {11'b0, 5'd15, 11'b0, 5'd14});
`else
    check("abort_counts", {11'b0, cnt[1], 11'b0, cnt[0]}, {11'b0, 5'd15, 11'b0, 5'd15});
`endif
    check("scoreboard_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
